// File: rtl/ntt_pkg.sv
// Shared constants and encodings for the Kyber NTT datapath and its neighbours.
package ntt_pkg;
    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;
    localparam int COEF_W  = 12;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_LOAD   = 2'd1,
        D_STREAM = 2'd2
    } drain_state_t;
endpackage

// File: rtl/pp_bank_ram.sv
// Simple dual-port DEPTH x W coefficient RAM: one write port, one synchronous read port.
// Read latency 1 cycle; a read of the address being written returns the old word.
// No backpressure: every enabled read or write is performed in its cycle.
module pp_bank_ram #(
    parameter int DEPTH = 128,
    parameter int W     = 12
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ntt_out_collector.sv
// Ping-pong collector: captures two-lane NTT output, re-emits N coefficients in natural order.
// Latency: last fill write at edge T gives out_valid after edge T+2; one beat per cycle after.
// Backpressure: outputs hold while stalled (skid behind RAM read); in_ready low when both banks busy.
module ntt_out_collector
    import ntt_pkg::*;
#(
    parameter int N = KYBER_N,
    parameter int W = COEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_mode,
    input  logic [W-1:0]         in1,
    input  logic [W-1:0]         in2,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 out_mode,
    output logic                 overflow
);
    localparam int IW = $clog2(N);
    localparam int AW = IW - 1;
    localparam logic [AW-1:0] WP_LAST  = AW'(N / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef struct packed {
        logic          mode;
        logic          last;
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } beat_t;

    bank_state_t   bank_st  [2];
    bank_state_t   bank_nxt [2];
    logic          bank_mode [2];
    logic          fill_bank, fill_nxt, drain_bank;
    logic [AW-1:0] wp;
    logic          wr;

    drain_state_t  d_state, d_nxt;
    logic          fire, last_fire, claim, claim_bank, space, rd_en, rd_bank, rd_all;
    logic [1:0]    occ;
    logic [IW-1:0] rp, rd_idx, rd_idx_q;
    logic          rd_vld_q, rd_bank_q;
    logic [W-1:0]  lo_q [2];
    logic [W-1:0]  hi_q [2];
    beat_t         rd_beat, skid, out_beat;
    logic          skid_vld;

    assign wr        = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign last_fire = fire && out_last;

    always_comb begin
        bank_nxt = bank_st;
        fill_nxt = fill_bank;
        if (wr) begin
            if (wp == WP_LAST) begin
                bank_nxt[fill_bank] = BANK_FULL;
                fill_nxt            = ~fill_bank;
            end else begin
                bank_nxt[fill_bank] = BANK_FILL;
            end
        end
        if (claim)     bank_nxt[claim_bank] = BANK_DRAIN;
        if (last_fire) bank_nxt[drain_bank] = BANK_EMPTY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_st[0]   <= BANK_EMPTY;
            bank_st[1]   <= BANK_EMPTY;
            bank_mode[0] <= MODE_NTT;
            bank_mode[1] <= MODE_NTT;
            fill_bank    <= 1'b0;
            drain_bank   <= 1'b0;
            wp           <= '0;
            in_ready     <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            bank_st   <= bank_nxt;
            fill_bank <= fill_nxt;
            // Registered: a bank freed this cycle only opens the input next cycle.
            in_ready  <= (bank_nxt[fill_nxt] == BANK_EMPTY) || (bank_nxt[fill_nxt] == BANK_FILL);
            if (wr) begin
                wp <= wp + 1'b1;
                if (wp == '0) bank_mode[fill_bank] <= in_mode;
            end
            if (in_valid && !in_ready) overflow <= 1'b1;
            if (last_fire) drain_bank <= ~drain_bank;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_state <= D_IDLE;
        else      d_state <= d_nxt;
    end

    always_comb begin
        d_nxt = d_state;
        case (d_state)
            D_IDLE:   if (bank_st[drain_bank] == BANK_FULL) d_nxt = D_LOAD;
            D_LOAD:   d_nxt = D_STREAM;
            D_STREAM: if (last_fire) d_nxt = (bank_st[~drain_bank] == BANK_FULL) ? D_LOAD : D_IDLE;
            default:  d_nxt = D_IDLE;
        endcase
    end

    // Reads are issued only while out register + skid + in-flight read can absorb them.
    always_comb begin
        occ        = 2'(out_valid) + 2'(skid_vld) + 2'(rd_vld_q);
        space      = (occ - 2'(fire)) < 2'd2;
        claim      = 1'b0;
        claim_bank = drain_bank;
        case (d_state)
            D_IDLE:   claim = (bank_st[drain_bank] == BANK_FULL);
            D_STREAM: begin
                claim      = last_fire && (bank_st[~drain_bank] == BANK_FULL);
                claim_bank = ~drain_bank;
            end
            default:  claim = 1'b0;
        endcase
        rd_en   = claim || ((d_state != D_IDLE) && !rd_all && space);
        rd_idx  = claim ? '0 : rp;
        rd_bank = claim ? claim_bank : drain_bank;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            rd_bank_q <= 1'b0;
            rp        <= '0;
            rd_all    <= 1'b1;
        end else begin
            rd_vld_q <= rd_en;
            if (rd_en) begin
                rd_idx_q  <= rd_idx;
                rd_bank_q <= rd_bank;
                rp        <= rd_idx + 1'b1;
                rd_all    <= (rd_idx == IDX_LAST);
            end
        end
    end

    always_comb begin
        rd_beat.mode = bank_mode[rd_bank_q];
        rd_beat.last = (rd_idx_q == IDX_LAST);
        rd_beat.idx  = rd_idx_q;
        rd_beat.data = rd_idx_q[IW-1] ? hi_q[rd_bank_q] : lo_q[rd_bank_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
            skid_vld  <= 1'b0;
            skid      <= '0;
        end else if (fire || !out_valid) begin
            out_valid <= skid_vld || rd_vld_q;
            if (skid_vld)      out_beat <= skid;
            else if (rd_vld_q) out_beat <= rd_beat;
            skid_vld <= skid_vld && rd_vld_q;
            if (rd_vld_q) skid <= rd_beat;
        end else if (rd_vld_q) begin
            skid_vld <= 1'b1;
            skid     <= rd_beat;
        end
    end

    assign out_data = out_beat.data;
    assign out_idx  = out_beat.idx;
    assign out_last = out_beat.last;
    assign out_mode = out_beat.mode;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic we_b, re_b;
        assign we_b = wr && (fill_bank == 1'(b));
        assign re_b = rd_en && (rd_bank == 1'(b));

        pp_bank_ram #(.DEPTH(N / 2), .W(W)) u_lo (
            .clk(clk), .we(we_b), .waddr(wp), .wdata(in1),
            .re(re_b), .raddr(rd_idx[AW-1:0]), .rdata(lo_q[b])
        );
        pp_bank_ram #(.DEPTH(N / 2), .W(W)) u_hi (
            .clk(clk), .we(we_b), .waddr(wp), .wdata(in2),
            .re(re_b), .raddr(rd_idx[AW-1:0]), .rdata(hi_q[b])
        );
    end
endmodule

// File: tb/tb_ntt_out_collector.sv
// Scoreboard bench for ntt_out_collector: directed polynomials, stalls, overflow, collisions, resets.
module tb_ntt_out_collector;
    import ntt_pkg::*;

    localparam int N  = KYBER_N;
    localparam int W  = COEF_W;
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic          mode;
        logic          last;
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_mode, in_ready;
    logic [W-1:0]  in1, in2;
    logic          out_valid, out_ready, out_last, out_mode, overflow;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t sb [$];
    bit    rnd_rdy  = 1'b0;

    always #5 clk = ~clk;

    ntt_out_collector #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_mode(in_mode), .in1(in1), .in2(in2), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_mode(out_mode), .overflow(overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic mode, input int base);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.mode = mode;
            b.last = (i == N - 1);
            b.idx  = IW'(i);
            b.data = W'(base + i);
            sb.push_back(b);
        end
    endtask

    // Only beat 0 carries the real mode, so a latch on the wrong beat shows up.
    task automatic feed(input logic mode, input int base, input int nbeats, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            in_valid = 1'b1;
            in_mode  = (k == 0) ? mode : ~mode;
            in1      = W'(base + k);
            in2      = W'(base + k + N / 2);
            step();
            if (gaps && (k % 7 == 3)) begin
                in_valid = 1'b0;
                step();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 3000) begin
            step();
            cyc++;
        end
        check({name, "_drain_done"}, 64'(cyc < 3000), 64'(1));
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_in_ready"}, 64'(in_ready), 64'(1));
        check({name, "_out_valid"}, 64'(out_valid), 64'(0));
        check({name, "_out_fields"}, 64'({out_data, out_idx, out_last, out_mode}), 64'(0));
        check({name, "_overflow"}, 64'(overflow), 64'(0));
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        beat_t cur, prev, exp_b;
        bit    prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur = '{mode: out_mode, last: out_last, idx: out_idx, data: out_data};
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", 64'({out_valid, cur}), 64'({1'b1, prev}));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got idx %0d data 0x%0h, required no beat", out_idx, out_data);
                    end else begin
                        exp_b = sb.pop_front();
                        check("beat", 64'(cur), 64'(exp_b));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev       = cur;
            end
        end
    end

    initial begin
        int cyc;
        rst = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b1;
        step();

        // Single NTT polynomial: latency and full throughput.
        out_ready = 1'b1;
        push_exp(MODE_NTT, 0);
        feed(MODE_NTT, 0, N / 2, 1'b0);
        check("lat_after_T", 64'(out_valid), 64'(0));
        step();
        check("lat_after_T1", 64'(out_valid), 64'(0));
        step();
        check("lat_first_valid", 64'({out_valid, out_idx}), 64'({1'b1, IW'(0)}));
        cyc = 0;
        while (!(out_valid && out_last) && cyc < 600) begin
            step();
            cyc++;
        end
        check("throughput_cycles", 64'(cyc), 64'(N - 1));
        wait_drain("single");

        // Random backpressure with input gaps.
        rnd_rdy = 1'b1;
        push_exp(MODE_INTT, 'h155);
        feed(MODE_INTT, 'h155, N / 2, 1'b1);
        wait_drain("backpressure");
        rnd_rdy = 1'b0;

        // Three back-to-back polynomials with the consumer stalled.
        out_ready = 1'b0;
        push_exp(MODE_NTT, 'h100);
        feed(MODE_NTT, 'h100, N / 2, 1'b0);
        push_exp(MODE_INTT, 'h800);
        feed(MODE_INTT, 'h800, N / 2, 1'b0);
        check("both_busy_in_ready", 64'(in_ready), 64'(0));
        check("overflow_before_drop", 64'(overflow), 64'(0));
        feed(MODE_NTT, 'hF00, 10, 1'b0);
        check("overflow_set", 64'(overflow), 64'(1));
        check("in_ready_still_low", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        wait_drain("three");
        check("in_ready_after_drain", 64'(in_ready), 64'(1));
        check("overflow_sticky", 64'(overflow), 64'(1));

        #1 rst = 1'b0;
        #1 check("overflow_cleared", 64'(overflow), 64'(0));
        step();
        rst = 1'b1;
        step();

        // Free of B0 on the same edge as the final write into B1.
        out_ready = 1'b0;
        push_exp(MODE_NTT, 'h200);
        feed(MODE_NTT, 'h200, N / 2, 1'b0);
        repeat (4) step();
        check("stalled_idx0", 64'({out_valid, out_idx}), 64'({1'b1, IW'(0)}));
        push_exp(MODE_INTT, 'hA00);
        for (int c = 0; c < N; c++) begin
            out_ready = 1'b1;
            if (c >= N / 2) begin
                in_valid = 1'b1;
                in_mode  = (c == N / 2) ? MODE_INTT : MODE_NTT;
                in1      = W'('hA00 + c - N / 2);
                in2      = W'('hA00 + c);
            end
            if (c == N - 1) check("simul_last_aligned", 64'(out_valid && out_last), 64'(1));
            step();
        end
        in_valid = 1'b0;
        check("simul_out_valid_T", 64'(out_valid), 64'(0));
        check("simul_in_ready", 64'(in_ready), 64'(1));
        step();
        check("simul_out_valid_T1", 64'(out_valid), 64'(0));
        step();
        check("simul_first_b1", 64'({out_valid, out_idx, out_mode}), 64'({1'b1, IW'(0), 1'b1}));
        push_exp(MODE_NTT, 'h3C0);
        feed(MODE_NTT, 'h3C0, N / 2, 1'b0);
        check("refill_b0_in_ready", 64'(in_ready), 64'(0));
        check("simul_no_overflow", 64'(overflow), 64'(0));
        wait_drain("simul");

        // Reset mid-fill at beat 60.
        out_ready = 1'b1;
        push_exp(MODE_NTT, 'h050);
        feed(MODE_NTT, 'h050, 60, 1'b0);
        #2 rst = 1'b0;
        sb.delete();
        #1 check_reset_vals("rst_fill");
        step();
        rst = 1'b1;
        repeat (3) step();
        check("rst_fill_no_stale", 64'(out_valid), 64'(0));

        // Reset mid-drain at index 100.
        push_exp(MODE_INTT, 'h777);
        feed(MODE_INTT, 'h777, N / 2, 1'b0);
        cyc = 0;
        while (!(out_valid && out_idx == IW'(100)) && cyc < 400) begin
            step();
            cyc++;
        end
        check("reach_idx100", 64'({out_valid, out_idx}), 64'({1'b1, IW'(100)}));
        #2 rst = 1'b0;
        sb.delete();
        #1 check_reset_vals("rst_drain");
        step();
        rst = 1'b1;
        repeat (5) step();
        check("rst_drain_no_stale", 64'(out_valid), 64'(0));
        push_exp(MODE_NTT, 'h0AB);
        feed(MODE_NTT, 'h0AB, N / 2, 1'b0);
        wait_drain("fresh");

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_out_collector.md
# ntt_out_collector

Downstream neighbour of the two-lane MDC NTT/INTT pipeline. Captures the pipeline's dual-lane output stream (two 12-bit coefficients per cycle while its `done` is high) into a ping-pong buffer. Re-emits each 256-coefficient polynomial one coefficient per cycle, in natural index order, on a valid/ready stream. It also provides upstream flow control so the pipeline's `en` can be gated when both banks are occupied.

## Interface
Parameters:
- `N`, 256, coefficients per polynomial (power of two, ≥4)
- `W`, 12, coefficient width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  lane pair valid (driven by pipeline `done`)
- `in_mode`  in  1  0 = NTT, 1 = INTT; sampled on first beat of a polynomial
- `in1`  in  W  lane-1 coefficient (pipeline `o1`)
- `in2`  in  W  lane-2 coefficient (pipeline `o2`)
- `in_ready`  out  1  a bank is free or currently filling
- `out_valid`  out  1  output coefficient valid
- `out_ready`  in  1  consumer accepts
- `out_data`  out  W  coefficient
- `out_idx`  out  log2(N)  natural index of `out_data`
- `out_last`  out  1  marks index N-1
- `out_mode`  out  1  mode latched for the polynomial being drained
- `overflow`  out  1  sticky: `in_valid` seen while `in_ready`=0

## Operation
- Two banks, B0/B1. Each bank is two N/2×W RAMs, LO and HI, one write port each, so both lanes are written in one cycle.
- Bank states:
  - EMPTY→FILL: selected by the fill pointer.
  - FILL→FULL: on the N/2-th write.
  - FULL→DRAIN: when the drain FSM claims the bank.
  - DRAIN→EMPTY: on the `out_last` handshake.
- Fill:
  - Write pointer `wp` (log2(N)-1 bits) starts at 0 in the first EMPTY bank, B0 after reset.
  - On each `in_valid`&&`in_ready`: LO[wp]←`in1`, HI[wp]←`in2`, `wp`++.
  - Gaps in `in_valid` are allowed; `wp` holds.
  - `in_mode` is latched into the bank's mode flag on the beat where `wp`=0.
  - On `wp`=N/2-1: the bank goes FULL, `wp` wraps to 0, and the fill bank toggles.
- Index mapping: beat k, `in1` → index k; `in2` → index k+N/2.
- Drain FSM:
  - D_IDLE: when the oldest FULL bank exists, claim it, issue a read of index 0 → D_LOAD.
  - D_LOAD: the RAM data returns into the output register; assert `out_valid` → D_STREAM.
  - D_STREAM: on each handshake, advance read pointer `rp`.
    - `rp`<N/2 reads LO[rp]; otherwise it reads HI[rp-N/2].
    - The next read is prefetched so that `out_ready` held high yields one coefficient per cycle.
  - On the handshake with `out_last`: free the bank. If the other bank is FULL, go to D_LOAD (claiming it); else D_IDLE.
- Backpressure: while `out_valid`&&!`out_ready`, `out_data`/`out_idx`/`out_last`/`out_mode` hold stable. Use a one-entry skid register behind the RAM read.
- Banks drain in fill order; an older FULL bank always drains first.
- `in_ready`=0 only when both banks are FULL/DRAIN. A beat arriving then is dropped (no write, `wp` unchanged) and sets `overflow`. `overflow` clears only on reset.
- Simultaneous events in one cycle:
  - The last fill write of one bank and the `out_last` handshake of the other bank: both take effect; the fill bank toggles to the bank just freed.
  - `in_valid` in the cycle a bank frees: `in_ready` uses pre-edge state. It is registered, so it is 0 that cycle if both banks were busy.

## Timing
- Reset (async assert, sync release): banks EMPTY, `wp`=`rp`=0, drain FSM D_IDLE. Outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `out_mode`=0, `overflow`=0.
- Reset mid-polynomial discards all buffered data; no partial output after release.
- Latency: last fill write at edge T → `out_valid`=1 after edge T+2, with `out_idx`=0.
- Throughput: with `out_ready`=1 continuously, N coefficients on N consecutive cycles. Consecutive FULL banks incur a 1-cycle D_LOAD bubble.
- Sustained input (N/2 cycles per polynomial) exceeds output rate (N cycles). Upstream must honour `in_ready`.
- RAM: synchronous read, 1-cycle latency; write-first behaviour is not relied upon, since no bank is read and written simultaneously.

## Structure
- Shared package `ntt_pkg`: `KYBER_N`=256, `KYBER_Q`=3329, `COEF_W`=12, mode constants `MODE_NTT`=0 and `MODE_INTT`=1, bank-state encoding.
- One sub-module: `pp_bank_ram`, a simple dual-port N/2×W RAM with sync read. It is instantiated four times (B0/B1 × LO/HI).

## Test plan
- Single NTT polynomial: beats k=0..127 with `in1`=k, `in2`=k+128, `out_ready`=1. Expect `out_data`=`out_idx`=0..255 on consecutive cycles, `out_last` at 255, `out_mode`=0, first valid 2 cycles after beat 127.
- Backpressure: toggle `out_ready` randomly. Expect held outputs while stalled, no loss or duplication, same 0..255 sequence.
- Three back-to-back polynomials (`in_mode` 0,1,0) with `out_ready`=0 until the third starts: `in_ready` falls after the second fills. Third-polynomial beats assert `overflow` and are dropped. Outputs are polynomial 1 then 2 with `out_mode` 0 then 1.
- Simultaneous free/fill: time `out_last` of B0 on the same edge as the final write into B1. Expect the next fill to go to B0, the drain to continue B1 after one D_LOAD bubble, and `overflow`=0.
- Reset mid-fill at beat 60 and mid-drain at index 100. Expect all outputs at reset values immediately. After release, a fresh polynomial yields a clean 0..255 with no stale data.
